// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-stage types and constants
package cpu_pkg;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_VALID = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_NOP_INST = 32'h0000_0000;
  localparam logic [31:0] PC_INC       = 32'd4;

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - next-PC select: branch over jump over sequential PC+4
module pc_next_sel
  import cpu_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  input  logic        jump_i,
  input  logic [31:0] jump_addr_i,
  output logic [31:0] next_pc_o,
  output logic        redirect_o
);

  always_comb begin
    redirect_o = branch_i | jump_i;
    if (branch_i) begin
      next_pc_o = branch_addr_i;
    end else if (jump_i) begin
      next_pc_o = jump_addr_i;
    end else begin
      next_pc_o = pc_i + PC_INC;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - IF stage: PC, imem handshake, redirect/stall, IF/ID register
// Optional perf counters under IF_PERF_CNT_EN.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  input  logic        jump_i,
  input  logic [31:0] jump_addr_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_data_i,
  output logic        valid_o,
  output logic [31:0] addedPC_o,
  output logic [31:0] inst_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  drain_addr_q, drain_addr_d;
  logic         valid_q, valid_d;
  logic [31:0]  added_pc_q, added_pc_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  next_pc;
  logic         redirect;
  logic         accept;

  pc_next_sel u_pc_next_sel (
    .pc_i          (pc_q),
    .branch_i      (branch_i),
    .branch_addr_i (branch_addr_i),
    .jump_i        (jump_i),
    .jump_addr_i   (jump_addr_i),
    .next_pc_o     (next_pc),
    .redirect_o    (redirect)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    valid_d      = valid_q;
    added_pc_d   = added_pc_q;
    inst_d       = inst_q;
    accept       = 1'b0;

    if (redirect) begin
      pc_d       = next_pc;
      valid_d    = 1'b0;
      added_pc_d = 32'd0;
      inst_d     = NOP_INST;
    end

    case (state_q)
      S_REQ: begin
        if (redirect) begin
          // An unanswered request must still be completed, so remember its address.
          if (!imem_ready_i) begin
            state_d      = S_DRAIN;
            drain_addr_d = pc_q;
          end
        end else if (imem_ready_i) begin
          inst_d     = imem_data_i;
          added_pc_d = next_pc;
          valid_d    = 1'b1;
          pc_d       = next_pc;
          state_d    = S_VALID;
        end
      end
      S_VALID: begin
        if (redirect) begin
          state_d = S_REQ;
        end else if (!stall_i) begin
          accept  = 1'b1;
          valid_d = 1'b0;
          state_d = S_REQ;
        end
      end
      S_DRAIN: begin
        if (imem_ready_i) begin
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
      valid_q      <= 1'b0;
      added_pc_q   <= 32'd0;
      inst_q       <= NOP_INST;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      valid_q      <= valid_d;
      added_pc_q   <= added_pc_d;
      inst_q       <= inst_d;
    end
  end

  assign imem_req_o  = rst_i && (state_q != S_VALID);
  assign imem_addr_o = (state_q == S_DRAIN) ? drain_addr_q : pc_q;
  assign valid_o     = valid_q;
  assign addedPC_o   = added_pc_q;
  assign inst_o      = valid_q ? inst_q : NOP_INST;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, flush_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      fetch_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (accept) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (redirect) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed-vector bench for instr_fetch
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch;
  logic [31:0] branch_addr;
  logic        jump;
  logic [31:0] jump_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        ready;
  logic [31:0] imem_data;
  logic        valid;
  logic [31:0] added_pc;
  logic [31:0] inst;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] flush_cnt;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  instr_fetch dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .stall_i       (stall),
    .branch_i      (branch),
    .branch_addr_i (branch_addr),
    .jump_i        (jump),
    .jump_addr_i   (jump_addr),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_ready_i  (ready),
    .imem_data_i   (imem_data),
    .valid_o       (valid),
    .addedPC_o     (added_pc),
    .inst_o        (inst)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt_o   (fetch_cnt),
    .flush_cnt_o   (flush_cnt)
`endif
  );

  assign imem_data = ready ? (imem_addr | 32'hA000_0000) : 32'hDEAD_BEEF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; ready = 1'b1;
    branch = 1'b0; branch_addr = 32'd0; jump = 1'b0; jump_addr = 32'd0;
    step(); step();
    check("rst_req",   {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_added", added_pc, 32'd0);
    check("rst_inst",  inst, 32'd0);

    // 1: back-to-back fetches with zero-wait memory
    rst = 1'b1; #1;
    check("t1_req0",  {31'd0, imem_req}, 32'd1);
    check("t1_addr0", imem_addr, 32'h0);
    step();
    check("t1_valid0", {31'd0, valid}, 32'd1);
    check("t1_added0", added_pc, 32'h4);
    check("t1_inst0",  inst, 32'hA000_0000);
    check("t1_idle0",  {31'd0, imem_req}, 32'd0);
    step();
    check("t1_addr4",  imem_addr, 32'h4);
    check("t1_inval",  {31'd0, valid}, 32'd0);
    step();
    check("t1_added4", added_pc, 32'h8);
    check("t1_inst4",  inst, 32'hA000_0004);

    // 3: stall holds the IF/ID register
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("t3_valid", {31'd0, valid}, 32'd1);
      check("t3_added", added_pc, 32'h8);
      check("t3_req",   {31'd0, imem_req}, 32'd0);
    end
    stall = 1'b0;
    step();
    check("t3_addr8", imem_addr, 32'h8);
    check("t3_req8",  {31'd0, imem_req}, 32'd1);
    step();
    check("t1_added8", added_pc, 32'hC);
    check("t1_inst8",  inst, 32'hA000_0008);

    // 4: branch beats jump
    branch = 1'b1; branch_addr = 32'h100; jump = 1'b1; jump_addr = 32'h200;
    step();
    branch = 1'b0; jump = 1'b0;
    check("t4_valid", {31'd0, valid}, 32'd0);
    check("t4_inst",  inst, 32'h0);
    check("t4_added", added_pc, 32'h0);
    check("t4_addr",  imem_addr, 32'h100);
    step();
    check("t4_added2", added_pc, 32'h104);
    check("t4_inst2",  inst, 32'hA000_0100);

    // 5: jump while a request is outstanding drains the old one
    ready = 1'b0; branch = 1'b1; branch_addr = 32'h40;
    step();
    branch = 1'b0;
    check("t5_addr40", imem_addr, 32'h40);
    jump = 1'b1; jump_addr = 32'h200;
    step();
    jump = 1'b0;
    check("t5_drain1", imem_addr, 32'h40);
    check("t5_dreq",   {31'd0, imem_req}, 32'd1);
    step();
    check("t5_drain2", imem_addr, 32'h40);
    ready = 1'b1;
    step();
    check("t5_novalid", {31'd0, valid}, 32'd0);
    check("t5_addr200", imem_addr, 32'h200);
    step();
    check("t5_added", added_pc, 32'h204);
    check("t5_inst",  inst, 32'hA000_0200);

    // 6: reset in S_DRAIN
    ready = 1'b0;
    step();
    check("t6_addr", imem_addr, 32'h204);
    jump = 1'b1; jump_addr = 32'h300;
    step();
    jump = 1'b0;
    check("t6_drain", imem_addr, 32'h204);
    rst = 1'b0;
    step();
    check("t6_req",   {31'd0, imem_req}, 32'd0);
    check("t6_valid", {31'd0, valid}, 32'd0);

    // 2: three wait states on address 0
    rst = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      check("t2_wreq",  {31'd0, imem_req}, 32'd1);
      check("t2_waddr", imem_addr, 32'h0);
      check("t2_wval",  {31'd0, valid}, 32'd0);
      step();
    end
    ready = 1'b1; #1;
    check("t2_raddr", imem_addr, 32'h0);
    step();
    check("t2_valid", {31'd0, valid}, 32'd1);
    check("t2_added", added_pc, 32'h4);
    check("t2_inst",  inst, 32'hA000_0000);
    step();
    check("t2_nodup", imem_addr, 32'h4);
    step();
    check("t2_added8", added_pc, 32'h8);

    // PC wrap at the top of the address space
    branch = 1'b1; branch_addr = 32'hFFFF_FFFC;
    step();
    branch = 1'b0;
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    check("wrap_added", added_pc, 32'h0);
    check("wrap_inst",  inst, 32'hFFFF_FFFC);
    step();
    check("wrap_next", imem_addr, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
